// File: rtl/therm_level_filter.sv
// Thermometer bubble-correct/decode, stability-filtered level commit with
// valid/ready handoff and decaying peak-hold. THERM_LEVEL_GRAY_OUT_EN: Gray-coded level/peak ports.
module therm_level_filter #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned PEAK_DECAY    = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] therm_in,
    input  logic       in_valid,
    output logic [2:0] level,
    output logic       level_valid,
    input  logic       level_ready,
    output logic       overrun,
    output logic       bubble_err,
    output logic [2:0] peak
);

    localparam logic [3:0] STAB_MAX  = 4'(STABLE_CYCLES);
    localparam logic [7:0] DECAY_TOP = 8'(PEAK_DECAY - 1);

    logic [6:0] t_q;
    logic       v1;
    logic [2:0] candidate, lvl, pk;
    logic [3:0] stab_cnt;
    logic [7:0] decay_cnt;

    logic [8:0] t_ext;
    logic [6:0] corr;
    logic [2:0] dec;
    logic       legal;

    logic [2:0] cand_nxt, lvl_nxt, pk_nxt;
    logic [3:0] stab_nxt;
    logic [7:0] dcnt_nxt;
    logic       commit, vld_nxt, ovr_nxt;

    // Out-of-range neighbours: below bit0 reads as 1, above bit6 as 0.
    assign t_ext = {1'b0, t_q, 1'b1};

    always_comb begin
        corr = '0;
        dec  = '0;
        for (int i = 0; i < 7; i++) begin
            corr[i] = (t_ext[i] & t_ext[i+1]) | (t_ext[i] & t_ext[i+2]) | (t_ext[i+1] & t_ext[i+2]);
            dec     = dec + 3'(corr[i]);
        end
    end

    // Legal code 0..01..1 means t+1 is a power of two, so t & (t+1) == 0.
    assign legal = (({1'b0, t_q} & ({1'b0, t_q} + 8'd1)) == 8'd0);

    always_comb begin
        cand_nxt = candidate;
        stab_nxt = stab_cnt;
        if (v1) begin
            if (dec != candidate) begin
                cand_nxt = dec;
                stab_nxt = 4'd1;
            end else if (stab_cnt < STAB_MAX) begin
                stab_nxt = stab_cnt + 4'd1;
            end
        end
        commit  = v1 && (stab_nxt == STAB_MAX) && (cand_nxt != lvl);
        lvl_nxt = commit ? cand_nxt : lvl;
        ovr_nxt = commit && level_valid && !level_ready;
        vld_nxt = level_valid;
        if (commit)           vld_nxt = 1'b1;
        else if (level_ready) vld_nxt = 1'b0;
    end

    // Decay is measured against the post-edge level so peak never dips below it.
    always_comb begin
        pk_nxt   = pk;
        dcnt_nxt = decay_cnt;
        if (commit && (cand_nxt > pk)) begin
            pk_nxt   = cand_nxt;
            dcnt_nxt = '0;
        end else if (pk > lvl_nxt) begin
            if (decay_cnt >= DECAY_TOP) begin
                pk_nxt   = pk - 3'd1;
                dcnt_nxt = '0;
            end else begin
                dcnt_nxt = decay_cnt + 8'd1;
            end
        end else begin
            dcnt_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q         <= '0;
            v1          <= 1'b0;
            candidate   <= '0;
            stab_cnt    <= '0;
            lvl         <= '0;
            level_valid <= 1'b0;
            overrun     <= 1'b0;
            bubble_err  <= 1'b0;
            pk          <= '0;
            decay_cnt   <= '0;
        end else begin
            v1          <= in_valid;
            if (in_valid) t_q <= therm_in;
            candidate   <= cand_nxt;
            stab_cnt    <= stab_nxt;
            lvl         <= lvl_nxt;
            level_valid <= vld_nxt;
            overrun     <= ovr_nxt;
            bubble_err  <= v1 && !legal;
            pk          <= pk_nxt;
            decay_cnt   <= dcnt_nxt;
        end
    end

`ifdef THERM_LEVEL_GRAY_OUT_EN
    assign level = lvl ^ (lvl >> 1);
    assign peak  = pk ^ (pk >> 1);
`else
    assign level = lvl;
    assign peak  = pk;
`endif

endmodule
